cook_timer_ctrl: RTL
====================

COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

Interface
REQ-001 Parameter: DONE_TICKS, default 3, number of tick_1hz pulses spent in DONE before automatic return to IDLE (range 1..15).
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-004 Port: tick_1hz  input  1  one-clk-wide pulse, once per second.
REQ-005 Port: preset_bcd  input  16  BCD mm:ss, ordered [15:12] min tens, [11:8] min units, [7:4] sec tens, [3:0] sec units.
REQ-006 Port: load  input  1  pulse; captures preset_bcd.
REQ-007 Port: start  input  1  pulse; begin or resume cooking.
REQ-008 Port: stop_clear  input  1  pulse; pause, or clear when already paused.
REQ-009 Port: door_closed  input  1  level; 1 = door shut.
REQ-010 Port: time_bcd  output  16  remaining time, same digit layout as preset_bcd.
REQ-011 Port: mag_on  output  1  magnetron enable.
REQ-012 Port: done  output  1  cooking-finished indicator.
REQ-013 Port: state  output  2  encoded FSM state.

Function
REQ-014 FSM states and encodings SHALL be IDLE=0, COOK=1, PAUSE=2, DONE=3.
REQ-015 mag_on SHALL be 1 only in COOK, and done SHALL be 1 only in DONE; both decode directly from the state register with no added latency.
REQ-016 In IDLE or PAUSE, load SHALL capture preset_bcd into time_bcd on the next edge.
REQ-017 On load, min digits above 9 SHALL saturate to 9 and sec tens above 5 SHALL saturate to 5.
REQ-018 load SHALL be ignored in COOK.
REQ-019 In DONE, load SHALL capture (with the same saturation) and move the FSM to IDLE.
REQ-020 In IDLE or PAUSE, start SHALL move the FSM to COOK only when door_closed=1 and time_bcd≠0000; otherwise start SHALL be ignored.
REQ-021 In COOK, each tick_1hz SHALL decrement time_bcd by one second.
REQ-022 The decrement SHALL use per-digit borrow chaining:
- sec units 0→9 borrows from sec tens;
- sec tens 0→5 borrows from min units;
- min units 0→9 borrows from min tens.
REQ-023 In COOK, a tick with time_bcd=0001 SHALL write 0000 and enter DONE on the same edge.
REQ-024 In COOK, door_closed=0 or stop_clear SHALL enter PAUSE with time held.
REQ-025 In COOK, if a tick coincides with door_closed=0 or stop_clear, there SHALL be no decrement.
REQ-026 In PAUSE, stop_clear SHALL clear time_bcd to 0000 and enter IDLE.
REQ-027 In IDLE, stop_clear SHALL clear time_bcd to 0000.
REQ-028 In DONE, a tick counter SHALL count tick_1hz pulses and return the FSM to IDLE after DONE_TICKS ticks.
REQ-029 In DONE, stop_clear or door_closed=0 SHALL return the FSM to IDLE immediately.
REQ-030 The DONE tick counter SHALL clear on DONE entry.
REQ-031 Simultaneous-input priority SHALL be: stop_clear > door open > load > start > tick.
REQ-032 start on the same edge that enters COOK SHALL NOT cause a decrement; only ticks sampled while already in COOK decrement.
REQ-033 time_bcd SHALL never hold an invalid BCD digit, and SHALL never wrap below 0000.

Reset
REQ-034 rstn=0 SHALL asynchronously force state=IDLE, time_bcd=0000, DONE tick counter=0, mag_on=0 and done=0.
REQ-035 Reset asserted mid-COOK SHALL drop mag_on immediately, without waiting for clk.
REQ-036 After rstn deasserts, the first edge SHALL process inputs normally.

Structure
REQ-037 A shared package SHALL hold the state encodings, the BCD digit maxima (9, 5) and the zero-time constant.
REQ-038 One sub-module, bcd_digit_down (parameterised modulus, borrow-in/borrow-out, load, clear), SHALL be instantiated four times.
REQ-039 The FSM and the DONE tick counter SHALL reside in cook_timer_ctrl.

Verification
REQ-040 load 0130, start, door closed, 2 ticks -> time 0128, mag_on=1 throughout.
REQ-041 time 0100 in COOK, 1 tick -> 0059; time 1000, 1 tick -> 0959.
REQ-042 time 0002, 2 ticks -> 0000, DONE, done=1, mag_on=0 on the same edge; 3 further ticks -> IDLE.
REQ-043 COOK at 0045, door_closed=0 and tick in the same cycle -> PAUSE, time 0045.
REQ-044 From REQ-043, start with door open -> stays PAUSE; start with door closed -> COOK.
REQ-045 load 9999 -> time 9959.
REQ-046 start with time 0000 -> stays IDLE.
REQ-047 stop_clear twice from COOK -> PAUSE then IDLE, time 0000.
REQ-048 rstn pulse mid-COOK -> mag_on=0 immediately, time 0000.

Source files
------------

// File: rtl/cook_timer_ctrl_pkg.sv
// Shared definitions for the cooking timer: FSM encodings, BCD digit limits
// and time constants.
package cook_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOK  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0]  BCD_MAX_9    = 4'd9;
  localparam logic [3:0]  BCD_MAX_5    = 4'd5;
  localparam logic [15:0] TIME_ZERO    = 16'h0000;
  localparam logic [15:0] TIME_ONE_SEC = 16'h0001;

  function automatic logic [3:0] bcd_sat(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/cook_timer_ctrl_bcd_digit_down.sv
// One down-counting BCD digit with saturating load, synchronous clear and
// borrow chaining to the next more significant digit.
module bcd_digit_down
  import cook_timer_ctrl_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX_9
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       borrow_in,
  output logic [3:0] value,
  output logic       borrow_out
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          value <= '0;
    else if (clear)     value <= '0;
    else if (load)      value <= bcd_sat(load_val, MAX);
    else if (borrow_in) value <= (value == '0) ? MAX : value - 4'd1;
  end

  assign borrow_out = borrow_in && (value == '0);

endmodule

// File: rtl/cook_timer_ctrl.sv
// Microwave cooking timer: mm:ss BCD countdown with IDLE/COOK/PAUSE/DONE
// control and an automatic return to IDLE after DONE_TICKS seconds in DONE.
module cook_timer_ctrl
  import cook_timer_ctrl_pkg::*;
#(
  parameter int unsigned DONE_TICKS = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick_1hz,
  input  logic [15:0] preset_bcd,
  input  logic        load,
  input  logic        start,
  input  logic        stop_clear,
  input  logic        door_closed,
  output logic [15:0] time_bcd,
  output logic        mag_on,
  output logic        done,
  output logic [1:0]  state
);

  localparam logic [3:0] LAST_TICK = 4'(DONE_TICKS - 1);

  state_t     state_q, state_d;
  logic [3:0] done_cnt;
  logic       time_clear, time_load, time_dec;
  logic       time_nonzero;
  logic [4:0] borrow;
  logic [3:0] sec_units, sec_tens, min_units, min_tens;

  assign time_bcd     = {min_tens, min_units, sec_tens, sec_units};
  assign time_nonzero = (time_bcd != TIME_ZERO);
  assign state        = state_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Each branch is ordered stop_clear > door open > load > start > tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, PAUSE: begin
        if (stop_clear)                                     state_d = IDLE;
        else if (!load && start && door_closed && time_nonzero) state_d = COOK;
      end
      COOK: begin
        if (stop_clear || !door_closed)                     state_d = PAUSE;
        else if (tick_1hz && time_bcd == TIME_ONE_SEC)      state_d = DONE;
      end
      DONE: begin
        if (stop_clear || !door_closed || load)             state_d = IDLE;
        else if (tick_1hz && done_cnt == LAST_TICK)         state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mag_on     = (state_q == COOK);
    done       = (state_q == DONE);
    time_clear = stop_clear && (state_q == IDLE || state_q == PAUSE);
    time_load  = load && !stop_clear &&
                 ((state_q == IDLE) || (state_q == PAUSE) ||
                  (state_q == DONE && door_closed));
    time_dec   = (state_q == COOK) && tick_1hz && !stop_clear && door_closed && time_nonzero;
  end

  // Held at zero outside DONE, so it is already clear on every DONE entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                     done_cnt <= '0;
    else if (state_q != DONE || state_d != DONE)   done_cnt <= '0;
    else if (tick_1hz)                             done_cnt <= done_cnt + 4'd1;
  end

  assign borrow[0] = time_dec;

  bcd_digit_down #(.MAX(BCD_MAX_9)) u_sec_units (
    .clk(clk), .rstn(rstn), .clear(time_clear), .load(time_load),
    .load_val(preset_bcd[3:0]), .borrow_in(borrow[0]),
    .value(sec_units), .borrow_out(borrow[1])
  );

  bcd_digit_down #(.MAX(BCD_MAX_5)) u_sec_tens (
    .clk(clk), .rstn(rstn), .clear(time_clear), .load(time_load),
    .load_val(preset_bcd[7:4]), .borrow_in(borrow[1]),
    .value(sec_tens), .borrow_out(borrow[2])
  );

  bcd_digit_down #(.MAX(BCD_MAX_9)) u_min_units (
    .clk(clk), .rstn(rstn), .clear(time_clear), .load(time_load),
    .load_val(preset_bcd[11:8]), .borrow_in(borrow[2]),
    .value(min_units), .borrow_out(borrow[3])
  );

  bcd_digit_down #(.MAX(BCD_MAX_9)) u_min_tens (
    .clk(clk), .rstn(rstn), .clear(time_clear), .load(time_load),
    .load_val(preset_bcd[15:12]), .borrow_in(borrow[3]),
    .value(min_tens), .borrow_out(borrow[4])
  );

  // A borrow out of the top digit would mean wrapping below 00:00.
  no_underflow: assert property (@(posedge clk) disable iff (!rstn) !borrow[4]);

endmodule
